// File: rtl/md_unit_if.sv
// Bus between the MIPS datapath and the multiply/divide unit.
// The datapath is the master: it launches operations, writes HI/LO and reads them back.
interface md_unit_if;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    modport master (
        output start, md_op, a, b, hi_we, lo_we, wdata, rd_sel,
        input  busy, hi, lo, rdata
    );

    modport slave (
        input  start, md_op, a, b, hi_we, lo_we, wdata, rd_sel,
        output busy, hi, lo, rdata
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit that owns HI/LO for mult/multu/div/divu and mthi/mtlo.
// state | meaning
// IDLE  | no operation in flight; accepts start or mthi/mtlo writes
// RUN   | operation in flight; counter holds the cycles remaining until commit
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic           load;
    logic           commit;
    logic           commit_wr;

    logic [63:0]    prod_s;
    logic [63:0]    prod_u;
    logic           is_sdiv;
    logic           div_zero;
    logic [31:0]    mag_a;
    logic [31:0]    mag_b;
    logic [31:0]    divisor;
    logic [31:0]    quo_u;
    logic [31:0]    rem_u;
    logic           quo_neg;
    logic           rem_neg;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide works on magnitudes; 0x80000000 is a valid unsigned magnitude of 2^31,
    // so the overflow case needs no special handling.
    assign is_sdiv  = (op_q == OP_DIV);
    assign div_zero = (b_q == 32'd0);
    assign mag_a    = (is_sdiv && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign mag_b    = (is_sdiv && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign divisor  = div_zero ? 32'd1 : mag_b;
    assign quo_u    = mag_a / divisor;
    assign rem_u    = mag_a % divisor;
    assign quo_neg  = is_sdiv && (a_q[31] ^ b_q[31]);
    assign rem_neg  = is_sdiv && a_q[31];

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            default: begin
                res_lo = quo_neg ? (32'd0 - quo_u) : quo_u;
                res_hi = rem_neg ? (32'd0 - rem_u) : rem_u;
            end
        endcase
    end

    // A divide by zero still takes the full latency but leaves HI/LO untouched.
    assign commit_wr = commit && !(op_q[1] && div_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (load) begin
                op_q <= bus.md_op;
                a_q  <= bus.a;
                b_q  <= bus.b;
                cnt  <= bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end
            if (commit_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == IDLE && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.rdata = bus.rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, arithmetic, corner cases, interference, rdata mux.
`timescale 1ns/1ps
module tb_md_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.md_op  = 2'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = 32'd0;
        bus.rd_sel = 1'b0;
    endtask

    task automatic write_hi(input logic [31:0] d);
        bus.hi_we = 1'b1;
        bus.wdata = d;
        tick();
        bus.hi_we = 1'b0;
    endtask

    task automatic write_lo(input logic [31:0] d);
        bus.lo_we = 1'b1;
        bus.wdata = d;
        tick();
        bus.lo_we = 1'b0;
    endtask

    // Launch an operation and count the cycles busy stays high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        bus.md_op = op;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = 32'h1357_9BDF;
        bus.b     = 32'h0000_0007;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL run_op_timeout: busy still high after %0d cycles, required fall", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        checks++;
        if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    endtask

    task automatic test_reset_mid_op();
        write_hi(32'h55);
        write_lo(32'h66);
        bus.md_op = 2'd0;
        bus.a     = 32'hFFFF_FFFE;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset: got %b want 1", bus.busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL mid_reset_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo);
        end
        repeat (8) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL mid_reset_no_commit: got busy=%b hi=%h lo=%h want 0/0/0",
                               bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        int n;
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL mult_latency: got %0d want 5", n); end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
        checks++;
        if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
        run_op(2'd1, 32'hFFFF_FFFE, 32'd3, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL multu_latency: got %0d want 5", n); end
        checks++;
        if (bus.hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi: got %h want 00000002", bus.hi); end
        checks++;
        if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo: got %h want fffffffa", bus.lo); end
    endtask

    task automatic test_div();
        int n;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL div_latency: got %0d want 10", n); end
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
        run_op(2'd3, 32'd7, 32'd2, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL divu_latency: got %0d want 10", n); end
        checks++;
        if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin
            errors++; $display("FAIL divu_result: got hi=%h lo=%h want 1/3", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_corner();
        int n;
        write_hi(32'h11);
        write_lo(32'h22);
        checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            errors++; $display("FAIL mthi_mtlo: got hi=%h lo=%h want 11/22", bus.hi, bus.lo);
        end
        run_op(2'd2, 32'd1234, 32'd0, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL divzero_latency: got %0d want 10", n); end
        checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            errors++; $display("FAIL divzero_hilo: got hi=%h lo=%h want 11/22", bus.hi, bus.lo);
        end
        run_op(2'd3, 32'd99, 32'd0, n);
        checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            errors++; $display("FAIL divuzero_hilo: got hi=%h lo=%h want 11/22", bus.hi, bus.lo);
        end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h want 0/80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_busy_interference();
        int n;
        bus.md_op = 2'd0;
        bus.a     = 32'd5;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == 1) begin
                bus.start = 1'b1;
                bus.md_op = 2'd2;
                bus.a     = 32'd100;
                bus.b     = 32'd0;
                bus.hi_we = 1'b1;
                bus.wdata = 32'hDEAD;
            end
            tick();
            if (n == 1) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
            end
        end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL interfere_latency: got %0d want 5", n); end
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h23) begin
            errors++; $display("FAIL interfere_result: got hi=%h lo=%h want 0/23", bus.hi, bus.lo);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL interfere_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_start_with_mtlo();
        int n;
        bus.md_op = 2'd2;
        bus.a     = 32'd9;
        bus.b     = 32'd0;
        bus.start = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hBEEF;
        tick();
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.lo !== 32'h23) begin
            errors++; $display("FAIL same_edge_start: got busy=%b lo=%h want 1/23", bus.busy, bus.lo);
        end
        n = 1;
        while (bus.busy && n < 100) begin
            tick();
            if (bus.busy) n++;
        end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL same_edge_latency: got %0d want 10", n); end
        checks++;
        if (bus.lo !== 32'h23) begin errors++; $display("FAIL same_edge_lo: got %h want 23", bus.lo); end
    endtask

    task automatic test_rdata();
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h1234) begin
            errors++; $display("FAIL dual_write: got hi=%h lo=%h want 1234/1234", bus.hi, bus.lo);
        end
        write_hi(32'hAAAA_0000);
        write_lo(32'h0000_BBBB);
        bus.rd_sel = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 32'h0000_BBBB) begin errors++; $display("FAIL rdata_lo: got %h want 0000bbbb", bus.rdata); end
        bus.rd_sel = 1'b1;
        #1;
        checks++;
        if (bus.rdata !== 32'hAAAA_0000) begin errors++; $display("FAIL rdata_hi: got %h want aaaa0000", bus.rdata); end
        bus.md_op = 2'd1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.rdata !== 32'hAAAA_0000) begin
            errors++; $display("FAIL rdata_during_run: got busy=%b rdata=%h want 1/aaaa0000", bus.busy, bus.rdata);
        end
        repeat (5) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.rdata !== 32'd0 || bus.lo !== 32'd1) begin
            errors++; $display("FAIL rdata_after_commit: got busy=%b rdata=%h lo=%h want 0/0/1",
                               bus.busy, bus.rdata, bus.lo);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_mid_op();
        test_mult();
        test_div();
        test_div_corner();
        test_busy_interference();
        test_start_with_mtlo();
        test_rdata();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
